dmem_responder: RTL

- Data-memory responder at the M/W boundary of the 5-stage RV32I pipeline.
- Consumes the pipeline controller's M-stage store byte-enables (unshifted: 0001 sb, 0011 sh, 1111 sw) plus load requests.
- Shifts lanes and data by address offset; writes a word-organised synchronous RAM.
- Returns sign/zero-extended load data one cycle later, aligned with the W stage.
- After reset, sweeps the RAM to a known value, asserting busy so the pipeline stalls.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_load_align.sv | 27 ++
 rtl/dmem_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, FSM state type and misalignment rule for the data-memory responder
package dmem_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam logic [3:0] SB_EN = 4'b0001;
   localparam logic [3:0] SH_EN = 4'b0011;
   localparam logic [3:0] SW_EN = 4'b1111;

   typedef enum logic {CLEAR, RUN} state_e;

   // Stores are sized by their enable pattern; loads by funct3, unused codes count as words.
   function automatic logic is_misaligned(input logic       is_store,
                                          input logic [3:0] w_en,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
      logic half;
      logic word;
      if (is_store) begin
         half = (w_en == SH_EN);
         word = (w_en == SW_EN);
      end else begin
         half = (f3 == LH) || (f3 == LHU);
         word = !half && (f3 != LB) && (f3 != LBU);
      end
      return (half && (off == 2'd3)) || (word && (off != 2'd0));
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - extracts and extends a byte/half/word from a raw RAM word
// Bytes shifted past bit 31 are zero-filled, so misaligned accesses see truncated data.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  f3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted;

   assign shifted = word_i >> {off_i, 3'b000};

   always_comb begin
      data_o = shifted;
      case (f3_i)
         LB:      data_o = {{24{shifted[7]}}, shifted[7:0]};
         LH:      data_o = {{16{shifted[15]}}, shifted[15:0]};
         LBU:     data_o = {24'h0, shifted[7:0]};
         LHU:     data_o = {16'h0, shifted[15:0]};
         default: data_o = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M/W-stage data-memory responder with post-reset clear sweep
// DMEM_MISALIGN_TRAP_EN: suppress misaligned stores, zero misaligned loads, pulse err_misalign.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter logic [31:0] CLEAR_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_w_en,
   input  logic [31:0] req_wdata,
   input  logic        req_rd,
   input  logic [2:0]  req_f3,
   output logic        busy,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        err_misalign
);

   localparam int              DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       ram_q;
   logic [1:0]        off_q;
   logic [2:0]        f3_q;
   logic              vld_q;
   logic              mis_q;
   logic [31:0]       hold_q;

   logic [ADDR_W-1:0] idx;
   logic [1:0]        off;
   logic              store_acc;
   logic              load_acc;
   logic              mis;
   logic [3:0]        lanes;
   logic [31:0]       wdata_sh;
   logic [31:0]       aligned;

   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_idx;
   logic [31:0]       mem_wd;

   logic              unused_addr;

   assign idx         = req_addr[ADDR_W+1:2];
   assign off         = req_addr[1:0];
   assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

   assign store_acc = (state_q == RUN) && (req_w_en != 4'b0000);
   assign load_acc  = (state_q == RUN) && req_rd && (req_w_en == 4'b0000);
   assign mis       = is_misaligned(req_w_en != 4'b0000, req_w_en, req_f3, off);

   // Shifting into a 4-bit context drops lanes that would spill into the next word.
   assign lanes    = req_w_en << off;
   assign wdata_sh = req_wdata << {off, 3'b000};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = 1'b1;
      mem_we  = 1'b0;
      mem_be  = 4'b0000;
      mem_idx = idx;
      mem_wd  = wdata_sh;
      case (state_q)
         CLEAR: begin
            mem_we  = 1'b1;
            mem_be  = SW_EN;
            mem_idx = cnt_q;
            mem_wd  = CLEAR_VAL;
            cnt_d   = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            busy   = 1'b0;
            mem_we = store_acc && !(TRAP_EN && mis);
            mem_be = lanes;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
               mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
            end
         end
      end
      if (load_acc) begin
         ram_q <= mem_q[idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         off_q   <= 2'd0;
         f3_q    <= 3'd0;
         mis_q   <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= load_acc;
         hold_q  <= rdata;
         if (load_acc) begin
            off_q <= off;
            f3_q  <= req_f3;
            mis_q <= mis;
         end
      end
   end

   dmem_load_align u_align (
      .word_i (ram_q),
      .off_i  (off_q),
      .f3_i   (f3_q),
      .data_o (aligned)
   );

   // Between loads the output replays the previous cycle's value.
   assign rdata       = !vld_q ? hold_q : ((TRAP_EN && mis_q) ? 32'h0 : aligned);
   assign rdata_valid = vld_q;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= (store_acc || load_acc) && mis;
      end
   end

   assign err_misalign = err_q;
`else
   assign err_misalign = 1'b0;
`endif

endmodule
